boreal_dma_ring_engine: RTL and testbench

Memory-to-memory DMA engine driven by a 16-entry descriptor ring, sitting on the Boreal MMIO bus as a slave. It has a single-word master port into an SRAM tile. Software loads descriptors, sets HEAD and TAIL, then writes START. The engine copies each descriptor's words from source to destination, advancing HEAD until HEAD==TAIL, and accumulates a CRC-32 over every word it reads.

---
 rtl/boreal_dma_ring_engine.sv | 195 +++++++++++++++++++
 tb/tb_boreal_dma_ring_engine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_dma_ring_engine.sv
// Descriptor-ring DMA engine: MMIO slave for setup, single-word SRAM master
// for copies, CRC-32 accumulated over every word read.
module boreal_dma_ring_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        mem_sel,
  output logic        mem_wr,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RD_REQ, S_RD_WAIT,
    S_WR_REQ, S_WR_WAIT, S_NEXT, S_FINISH
  } state_t;

  state_t state, state_nx;

  logic [3:0]  head, tail;
  logic        busy, done;
  logic [31:0] crc;
  logic [31:0] cur_src, cur_dst, remaining, buffer;

  logic [31:0] desc_src [0:15];
  logic [31:0] desc_dst [0:15];
  logic [31:0] desc_len [0:15];

  logic [8:0] off;
  logic [3:0] didx;
  logic [1:0] dfld;
  logic       reg_wr, is_desc;
  logic       hit_head, hit_tail, hit_stat, hit_crc;
  logic       go;
  logic [3:0] head_inc;
  logic       unused_addr;

  assign off         = addr[8:0];
  assign didx        = off[7:4];
  assign dfld        = off[3:2];
  assign is_desc     = off[8];
  assign reg_wr      = sel & wr;
  assign hit_head    = off == 9'h000;
  assign hit_tail    = off == 9'h004;
  assign hit_stat    = off == 9'h008;
  assign hit_crc     = off == 9'h010;
  assign head_inc    = head + 4'd1;
  assign unused_addr = ^addr[31:9];

  assign go = reg_wr && off == 9'h00C && wdata[0]
           && !busy && state == S_IDLE && head != tail;

  // One reflected CRC-32 step over a whole word, LSB first.
  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [31:0] d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 32; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  always_comb begin
    rdata = '0;
    if (sel) begin
      if (is_desc) begin
        unique case (dfld)
          2'd0:    rdata = desc_src[didx];
          2'd1:    rdata = desc_dst[didx];
          2'd2:    rdata = desc_len[didx];
          default: rdata = '0;
        endcase
      end else begin
        unique case (1'b1)
          hit_head: rdata = {28'd0, head};
          hit_tail: rdata = {28'd0, tail};
          hit_stat: rdata = {30'd0, done, busy};
          hit_crc:  rdata = ~crc;
          default:  rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reg_wr && is_desc) begin
      unique case (dfld)
        2'd0:    desc_src[didx] <= wdata;
        2'd1:    desc_dst[didx] <= wdata;
        2'd2:    desc_len[didx] <= wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_sel   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      S_IDLE:    if (go) state_nx = S_LOAD;
      S_LOAD:    state_nx = (desc_len[head] == 32'd0) ? S_NEXT : S_RD_REQ;
      S_RD_REQ: begin
        mem_sel  = 1'b1;
        mem_addr = cur_src[11:2];
        state_nx = S_RD_WAIT;
      end
      S_RD_WAIT: if (mem_ack) state_nx = S_WR_REQ;
      S_WR_REQ: begin
        mem_sel   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = cur_dst[11:2];
        mem_wdata = buffer;
        state_nx  = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mem_ack)
          state_nx = (remaining == 32'd1) ? S_NEXT : S_RD_REQ;
      end
      S_NEXT:    state_nx = (head_inc != tail) ? S_LOAD : S_FINISH;
      S_FINISH:  state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack       <= 1'b0;
      head      <= '0;
      tail      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      crc       <= 32'hFFFFFFFF;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      buffer    <= '0;
    end else begin
      ack <= sel;
      if (reg_wr && hit_head && !busy) head <= wdata[3:0];
      if (reg_wr && hit_tail) tail <= wdata[3:0];
      if (reg_wr && hit_stat && wdata[1]) done <= 1'b0;
      if (go) begin
        busy <= 1'b1;
        done <= 1'b0;
        crc  <= 32'hFFFFFFFF;
      end
      // Engine events come last so they win over a same-cycle MMIO write.
      unique case (state)
        S_LOAD: begin
          cur_src   <= desc_src[head];
          cur_dst   <= desc_dst[head];
          remaining <= desc_len[head];
        end
        S_RD_WAIT: begin
          if (mem_ack) begin
            buffer <= mem_rdata;
            crc    <= crc_step(crc, mem_rdata);
          end
        end
        S_WR_WAIT: begin
          if (mem_ack) begin
            cur_src   <= cur_src + 32'd4;
            cur_dst   <= cur_dst + 32'd4;
            remaining <= remaining - 32'd1;
          end
        end
        S_NEXT:   head <= head_inc;
        S_FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boreal_dma_ring_engine.sv
// Randomized bench for the DMA ring engine: SRAM responder with random
// latency and a word-level copy/CRC reference model.
module tb_boreal_dma_ring_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sel = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack;
  logic        mem_sel;
  logic        mem_wr;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  boreal_dma_ring_engine dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .mem_sel(mem_sel),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // SRAM model with 1..3 cycle acknowledge latency
  logic [31:0] sram [0:1023];
  logic [31:0] ref_mem [0:1023];
  int          sel_cnt = 0;
  bit          pend = 0;
  int          cnt = 0;
  logic        p_wr;
  logic [9:0]  p_addr;
  logic [31:0] p_wdata;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend) begin
        if (cnt == 0) begin
          mem_ack = 1'b1;
          pend = 0;
          if (p_wr) sram[p_addr] = p_wdata;
          else      mem_rdata = sram[p_addr];
        end else begin
          cnt--;
        end
      end
      if (mem_sel) begin
        sel_cnt++;
        pend    = 1;
        cnt     = $urandom_range(0, 2);
        p_wr    = mem_wr;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
      end
    end
  end

  // Reference model: byte-table CRC-32 and a plain sequential copy
  logic [31:0] crc_tab [0:255];
  logic [31:0] m_src [0:15];
  logic [31:0] m_dst [0:15];
  logic [31:0] m_len [0:15];

  function automatic logic [31:0] crc_word(input logic [31:0] c,
                                           input logic [31:0] w);
    logic [31:0] r;
    logic [7:0]  b;
    r = c;
    for (int k = 0; k < 4; k++) begin
      b = r[7:0] ^ w[8*k +: 8];
      r = crc_tab[b] ^ (r >> 8);
    end
    return r;
  endfunction

  task automatic run_model(input int h0, input int t,
                           output logic [31:0] crc_rd);
    logic [31:0] c, sa, da, v;
    int h;
    c = 32'hFFFFFFFF;
    h = h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = sram[i];
    do begin
      for (int w = 0; w < int'(m_len[h]); w++) begin
        sa = m_src[h] + 32'(4 * w);
        da = m_dst[h] + 32'(4 * w);
        v  = ref_mem[sa[11:2]];
        c  = crc_word(c, v);
        ref_mem[da[11:2]] = v;
      end
      h = (h + 1) % 16;
    end while (h != t);
    crc_rd = ~c;
  endtask

  task automatic mw(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic mr(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; wr = 1'b0; addr = a;
    #1 d = rdata;
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic set_desc(input int i, input logic [31:0] s,
                          input logic [31:0] d, input logic [31:0] l);
    mw(32'h100 + 32'(i * 16), s);
    mw(32'h104 + 32'(i * 16), d);
    mw(32'h108 + 32'(i * 16), l);
    m_src[i] = s; m_dst[i] = d; m_len[i] = l;
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      mr(32'h8, s);
      n++;
    end while (s[0] && n < 3000);
    chk({tag, "_timeout"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic cmp_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (sram[i] !== ref_mem[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  logic [31:0] rd, exp_crc;
  int hh, tt;

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
    for (int i = 0; i < 1024; i++) sram[i] = $urandom;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ack", {31'd0, ack}, 32'h0);
    chk("rst_mem_sel", {31'd0, mem_sel}, 32'h0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mr(32'h0, rd);  chk("rst_head", rd, 32'h0);
    mr(32'h4, rd);  chk("rst_tail", rd, 32'h0);
    mr(32'h8, rd);  chk("rst_status", rd, 32'h0);
    mr(32'h10, rd); chk("rst_crc", rd, 32'h0);

    // Register readback and ack pulse
    mw(32'h0, 32'h5);
    chk("ack_pulse", {31'd0, ack}, 32'h1);
    @(negedge clk);
    chk("ack_drop", {31'd0, ack}, 32'h0);
    mr(32'h0, rd);  chk("head_5", rd, 32'h5);
    mw(32'h0, 32'h0);
    mw(32'h4, 32'h0);
    mr(32'h0, rd);  chk("head_0", rd, 32'h0);
    mr(32'h4, rd);  chk("tail_0", rd, 32'h0);
    mr(32'hC, rd);  chk("start_rd0", rd, 32'h0);
    mw(32'h20, 32'hFFFF_FFFF);
    mr(32'h20, rd); chk("unmapped", rd, 32'h0);
    mw(32'h10C, 32'h1234);
    mr(32'h10C, rd); chk("desc_rsvd", rd, 32'h0);

    // Empty ring
    sel_cnt = 0;
    mw(32'hC, 32'h1);
    repeat (10) @(negedge clk);
    mr(32'h8, rd);  chk("empty_status", rd, 32'h0);
    chk("empty_memsel", 32'(sel_cnt), 32'd0);

    // Single-word copy
    sram[0] = 32'hCAFEBABE;
    set_desc(0, 32'h0, 32'h190, 32'd1);
    mr(32'h104, rd); chk("desc_rb", rd, 32'h190);
    mw(32'h0, 32'h0);
    mw(32'h4, 32'h1);
    run_model(0, 1, exp_crc);
    mw(32'hC, 32'h1);
    wait_done("single");
    mr(32'h8, rd);  chk("single_status", rd, 32'h2);
    chk("single_word", sram[100], 32'hCAFEBABE);
    mr(32'h0, rd);  chk("single_head", rd, 32'h1);
    mr(32'h10, rd);
    chk("single_crc_nz", 32'(rd != 32'h0 && rd != 32'hFFFFFFFF), 32'd1);
    chk("single_crc", rd, exp_crc);

    // Two descriptors across the 15->0 wrap
    sram[0] = 32'hCAFEBABE; sram[1] = 32'hDEADBEEF;
    sram[2] = 32'h12345678; sram[3] = 32'hAAAABBBB;
    set_desc(15, 32'h0, 32'd800, 32'd2);
    set_desc(0, 32'h8, 32'd1200, 32'd2);
    mw(32'h0, 32'd15);
    mw(32'h4, 32'd1);
    run_model(15, 1, exp_crc);
    mw(32'hC, 32'h1);
    wait_done("wrap");
    mr(32'h8, rd);  chk("wrap_status", rd, 32'h2);
    mr(32'h0, rd);  chk("wrap_head", rd, 32'h1);
    chk("wrap_w0", sram[200], 32'hCAFEBABE);
    chk("wrap_w1", sram[201], 32'hDEADBEEF);
    chk("wrap_w2", sram[300], 32'h12345678);
    chk("wrap_w3", sram[301], 32'hAAAABBBB);
    mr(32'h10, rd); chk("wrap_crc", rd, exp_crc);

    // Writes to HEAD and START while busy are ignored
    set_desc(2, 32'h40, 32'h600, 32'd4);
    mw(32'h0, 32'd2);
    mw(32'h4, 32'd3);
    run_model(2, 3, exp_crc);
    sel_cnt = 0;
    mw(32'hC, 32'h1);
    mr(32'h8, rd);  chk("busy_status", rd, 32'h1);
    mw(32'h0, 32'd9);
    mw(32'hC, 32'h1);
    wait_done("busy");
    mr(32'h0, rd);  chk("busy_head", rd, 32'h3);
    chk("busy_memsel", 32'(sel_cnt), 32'd8);
    cmp_mem("busy_mem");
    mr(32'h10, rd); chk("busy_crc", rd, exp_crc);
    mw(32'h8, 32'h2);
    mr(32'h8, rd);  chk("done_clear", rd, 32'h0);

    // Zero-length descriptor
    set_desc(0, 32'h0, 32'h100, 32'd0);
    mw(32'h0, 32'd0);
    mw(32'h4, 32'd1);
    sel_cnt = 0;
    mw(32'hC, 32'h1);
    wait_done("zero");
    mr(32'h8, rd);  chk("zero_status", rd, 32'h2);
    chk("zero_memsel", 32'(sel_cnt), 32'd0);
    mr(32'h10, rd); chk("zero_crc", rd, 32'h0);

    // Reset in the middle of a long copy
    set_desc(4, 32'h0, 32'h800, 32'd20);
    mw(32'h0, 32'd4);
    mw(32'h4, 32'd5);
    mw(32'hC, 32'h1);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("abort_memsel", {31'd0, mem_sel}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mr(32'h8, rd);  chk("abort_status", rd, 32'h0);
    mr(32'h0, rd);  chk("abort_head", rd, 32'h0);
    mr(32'h10, rd); chk("abort_crc", rd, 32'h0);

    // Randomized rings
    for (int it = 0; it < 15; it++) begin
      for (int i = 0; i < 1024; i++) sram[i] = $urandom;
      for (int i = 0; i < 16; i++)
        set_desc(i, $urandom, $urandom, 32'($urandom_range(0, 6)));
      hh = $urandom_range(0, 15);
      tt = (hh + $urandom_range(1, 5)) % 16;
      mw(32'h0, 32'(hh));
      mw(32'h4, 32'(tt));
      run_model(hh, tt, exp_crc);
      mw(32'hC, 32'h1);
      wait_done($sformatf("rnd%0d", it));
      mr(32'h8, rd);  chk($sformatf("rnd%0d_status", it), rd, 32'h2);
      mr(32'h0, rd);  chk($sformatf("rnd%0d_head", it), rd, 32'(tt));
      mr(32'h10, rd); chk($sformatf("rnd%0d_crc", it), rd, exp_crc);
      cmp_mem($sformatf("rnd%0d_mem", it));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
